// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-path defines: default reset PC, PC step and instruction width.
package if_fetch_queue_pkg;

  localparam int unsigned IF_INST_W   = 32;
  localparam int unsigned IF_PC_STEP  = 4;
  localparam logic [63:0] IF_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/if_inst_fifo.sv
// Circular FIFO of fetched {inst, pc} entries with synchronous flush.
// Flush wins over push; push on a full FIFO is accepted only with a simultaneous pop.
module if_inst_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = IF_INST_W + 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: issues in-order fetch requests under a credit limit,
// queues responses with their PC, and discards stale responses after a redirect.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = IF_INST_W,
  parameter int unsigned       DEPTH    = 4,           // power of 2, >= 2
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic [INST_W-1:0] rsp_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int unsigned       CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned       ENT_W   = INST_W + ADDR_W;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(IF_PC_STEP);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] redirect_aligned;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              req_fire;
  logic              rsp_keep;
  logic [ENT_W-1:0]  head;

  assign redirect_aligned = redirect_addr & ~ADDR_W'(3);

  // Outstanding requests plus queued entries never exceed DEPTH, so a kept
  // response always finds room in the FIFO.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign req_valid   = rst && !redirect_valid && (credit_used < (CNT_W + 1)'(DEPTH));
  assign req_addr    = fetch_pc;
  assign req_fire    = req_valid && req_ready;

  assign rsp_keep  = rsp_valid && (drop_cnt == '0);
  assign fifo_push = rsp_keep && (!fifo_full || fifo_pop);

  assign out_valid = rst && !fifo_empty && !redirect_valid;
  assign fifo_pop  = out_valid && out_ready;
  assign out_inst  = rst ? head[ADDR_W +: INST_W] : '0;
  assign out_pc    = rst ? head[ADDR_W-1:0]       : RESET_PC;

  // PC tracking and in-flight/drop accounting; a redirect turns every response
  // still owed (excluding one consumed this cycle) into a drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (rsp_keep) rsp_pc   <= rsp_pc + PC_STEP;
      end
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(rsp_valid);
      if (redirect_valid) begin
        drop_cnt <= inflight - CNT_W'(rsp_valid);
      end else if (rsp_valid && !rsp_keep) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  if_inst_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({rsp_inst, rsp_pc}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus random traffic,
// checked against an epoch-tagged request/queue model of the fetch front end.
module tb_if_fetch_queue;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned INST_W   = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;
  logic              req_valid;
  logic              req_ready = 1'b0;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid = 1'b0;
  logic [INST_W-1:0] rsp_inst = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;

  always #5 clk = ~clk;

  if_fetch_queue #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_inst       (rsp_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  // Memory-side request record: address, cycle accepted, and fetch stream it belongs to.
  typedef struct {
    logic [63:0] addr;
    int unsigned cyc;
    int unsigned epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  mreq_t       mem_q[$];
  ent_t        m_fifo[$];
  logic [63:0] m_fetch_pc;
  int unsigned epoch;
  int unsigned cyc_no;
  int          checks;
  int          failures;

  logic        obs_req_valid;
  logic        obs_out_valid;
  logic [63:0] obs_req_addr;
  logic [63:0] obs_out_pc;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input logic rv, input logic [63:0] ra, input logic rr,
                      input logic ordy, input int unsigned pct);
    logic  exp_rv;
    logic  exp_ov;
    mreq_t r;
    ent_t  e;
    redirect_valid = rv;
    redirect_addr  = ra;
    req_ready      = rr;
    out_ready      = ordy;
    rsp_valid      = 1'b0;
    rsp_inst       = '0;
    if (mem_q.size() != 0 && mem_q[0].cyc < cyc_no && $urandom_range(99) < pct) begin
      rsp_valid = 1'b1;
      rsp_inst  = inst_of(mem_q[0].addr);
    end
    #4;
    exp_rv = !rv && ((mem_q.size() + m_fifo.size()) < DEPTH);
    exp_ov = !rv && (m_fifo.size() != 0);
    obs_req_valid = req_valid;
    obs_req_addr  = req_addr;
    obs_out_valid = out_valid;
    obs_out_pc    = out_pc;
    chk("req_valid", req_valid, exp_rv);
    if (exp_rv) chk("req_addr", req_addr, m_fetch_pc);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_pc", out_pc, m_fifo[0].pc);
      chk("out_inst", out_inst, m_fifo[0].inst);
    end
    if (exp_ov && ordy) void'(m_fifo.pop_front());
    if (rsp_valid) begin
      r = mem_q.pop_front();
      if (r.epoch == epoch && !rv) begin
        e.inst = inst_of(r.addr);
        e.pc   = r.addr;
        m_fifo.push_back(e);
      end
    end
    if (rv) begin
      m_fifo.delete();
      epoch++;
      m_fetch_pc = ra & ~64'd3;
    end else if (exp_rv && rr) begin
      r.addr  = m_fetch_pc;
      r.cyc   = cyc_no;
      r.epoch = epoch;
      mem_q.push_back(r);
      m_fetch_pc = m_fetch_pc + 64'd4;
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  // Assert reset, check outputs immediately, clear the model and memory side, release.
  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_inst       = '0;
    out_ready      = 1'b0;
    #1;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, RESET_PC);
    mem_q.delete();
    m_fifo.delete();
    m_fetch_pc = RESET_PC;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_out;
    int n_req;
    bit got;
    checks   = 0;
    failures = 0;
    cyc_no   = 0;
    epoch    = 0;

    do_reset();

    // Streaming: one instruction per cycle after two cycles of latency.
    n_out = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 64'd0, 1'b1, 1'b1, 100);
      if (obs_out_valid) n_out++;
    end
    chk("stream_throughput", n_out, 10);

    // Backpressure: decode stalled, exactly DEPTH requests accepted, then drain.
    do_reset();
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 64'd0, 1'b1, 1'b0, 100);
      if (obs_req_valid) n_req++;
    end
    chk("bp_accepted", n_req, 4);
    for (int i = 0; i < 8; i++) step(1'b0, 64'd0, 1'b1, 1'b1, 100);

    // Redirect with three outstanding requests.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1, 1'b1, 0);
    step(1'b1, 64'h0000_0000_8000_1000, 1'b1, 1'b1, 0);
    chk("no_req_on_redirect", obs_req_valid, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 64'd0, 1'b1, 1'b1, 100);
      if (obs_out_valid) begin
        got = 1'b1;
        chk("redirect_first_pc", obs_out_pc, 64'h0000_0000_8000_1000);
      end
    end
    if (!got) chk("redirect_first_out_timeout", got, 1'b1);

    // Redirect coinciding with a response and an attempted out handshake.
    for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b1, 1'b1, 100);
    step(1'b1, 64'h0000_0000_8000_2000, 1'b1, 1'b1, 100);
    step(1'b0, 64'd0, 1'b1, 1'b1, 100);
    chk("coincide_out_valid_next", obs_out_valid, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 64'd0, 1'b1, 1'b1, 100);

    // Wrap and alignment of the fetch address.
    do_reset();
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 100);
    step(1'b0, 64'd0, 1'b1, 1'b1, 100);
    chk("wrap_addr0", obs_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 64'd0, 1'b1, 1'b1, 100);
    chk("wrap_addr1", obs_req_addr, 64'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 64'd0, 1'b1, 1'b1, 100);

    // Reset mid-stream with requests in flight and entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1, 1'b0, 100);
    step(1'b0, 64'd0, 1'b1, 1'b0, 0);
    do_reset();
    step(1'b0, 64'd0, 1'b1, 1'b1, 100);
    chk("post_reset_req_addr", obs_req_addr, RESET_PC);

    // Random traffic with occasional redirects to arbitrary (possibly unaligned) targets.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(15) == 0), {$urandom, $urandom},
           ($urandom_range(3) != 0), ($urandom_range(3) != 0), 60);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 64'd0, 1'b1, 1'b1, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning PC/fetch address width.
REQ-002 SHALL have parameter INST_W, default 32, meaning instruction width; the PC step is 4.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries and the outstanding-request limit; power of 2, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 'h8000_0000, meaning the first fetch address after reset.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock, with all state on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-007 SHALL have port redirect_valid, input, 1 bit, meaning a jump or taken branch from execute.
REQ-008 SHALL have port redirect_addr, input, ADDR_W bits, meaning the redirect target; bits [1:0] are treated as zero.
REQ-009 SHALL have port req_valid, output, 1 bit, meaning a fetch request to instruction memory is valid.
REQ-010 SHALL have port req_ready, input, 1 bit, meaning memory accepts the request.
REQ-011 SHALL have port req_addr, output, ADDR_W bits, meaning the fetch address.
REQ-012 SHALL have port rsp_valid, input, 1 bit, meaning a response is valid: one per accepted request, in order, at least 1 cycle after acceptance, and never back-pressured.
REQ-013 SHALL have port rsp_inst, input, INST_W bits, meaning the response instruction.
REQ-014 SHALL have port out_valid, output, 1 bit, meaning an instruction is offered to decode.
REQ-015 SHALL have port out_ready, input, 1 bit, meaning decode accepts the instruction.
REQ-016 SHALL have port out_inst, output, INST_W bits, meaning the offered instruction.
REQ-017 SHALL have port out_pc, output, ADDR_W bits, meaning the address of out_inst.

Function
REQ-018 SHALL hold fetch_pc, rsp_pc, inflight (0..DEPTH), drop_cnt (0..DEPTH) and a DEPTH-entry FIFO of {inst, pc}.
REQ-019 SHALL drive req_valid = !redirect_valid && (inflight + fifo_count) < DEPTH, and req_addr = fetch_pc.
REQ-020 SHALL, on req_valid && req_ready, advance fetch_pc by 4 modulo 2^ADDR_W (wrap, no flag) and increment inflight.
REQ-021 SHALL decrement inflight on rsp_valid; a request and a response in the same cycle leave inflight unchanged.
REQ-022 SHALL, on rsp_valid with drop_cnt == 0, push {rsp_inst, rsp_pc} the same cycle and advance rsp_pc by 4; the credit rule in REQ-019 guarantees the FIFO is never full here.
REQ-023 SHALL, on rsp_valid with drop_cnt > 0, discard the response and decrement drop_cnt.
REQ-024 SHALL drive out_valid = !fifo_empty && !redirect_valid, with out_inst and out_pc from the FIFO head, and pop on out_valid && out_ready.
REQ-025 SHALL allow a push and a pop in the same cycle, including on a full FIFO or an empty-then-bypass-free FIFO, and SHALL leave the count unchanged (latency response to out_valid = 1 cycle, no bypass).
REQ-026 SHALL, on redirect_valid in cycle t, load fetch_pc and rsp_pc with redirect_addr, empty the FIFO, and issue no request in cycle t.
REQ-027 SHALL, on redirect_valid in cycle t, set drop_cnt to inflight minus (rsp_valid in t && drop_cnt == 0), also accounting for a response being dropped in t.
REQ-028 SHALL issue the first request at redirect_addr in cycle t+1 when req_ready permits.
REQ-029 SHALL treat back-to-back redirects so that the last one wins and drop_cnt always equals the responses still owed.
REQ-030 SHALL hold req_addr stable while req_valid is high and req_ready is low, unless a redirect occurs.

Reset
REQ-031 SHALL, while rst is low, asynchronously set fetch_pc = rsp_pc = RESET_PC, inflight = drop_cnt = 0, and the FIFO empty.
REQ-032 SHALL drive req_valid = 0 and out_valid = 0 during reset, with out_inst = 0 and out_pc = RESET_PC.
REQ-033 SHALL issue the first request at RESET_PC in the first cycle after rst deasserts.
REQ-034 SHALL lose all in-flight requests on reset mid-operation; the memory side is reset by the same rst.

Structure
REQ-035 SHALL take the default RESET_PC, the PC step (4) and the instruction width from the shared defines package, not as local literals.
REQ-036 SHALL place the FIFO in one sub-module, if_inst_fifo, with parameters WIDTH/DEPTH, ports push/pop/flush/full/empty/count, and a synchronous flush that has priority over push.
REQ-037 SHALL keep the remainder (PC, counters, handshake logic) in if_fetch_queue, at roughly 120-250 lines total.

Verification
REQ-038 SHALL cover streaming: req_ready = 1, 1-cycle response, out_ready = 1 -> requests at 0x80000000, 0x80000004, ...; out_pc sequence identical; throughput 1/cycle after 2 cycles.
REQ-039 SHALL cover backpressure: out_ready = 0 for 10 cycles, DEPTH = 4 -> exactly 4 requests accepted, req_valid low until the first pop, no entry lost or duplicated.
REQ-040 SHALL cover redirect with outstanding requests: 3 inflight, redirect to 0x80001000 -> the next 3 responses are dropped, first out_pc = 0x80001000, and no request is issued in the redirect cycle.
REQ-041 SHALL cover redirect coinciding with rsp_valid and an out handshake -> no pop counted, out_valid low, drop_cnt = inflight - 1, FIFO empty in the next cycle.
REQ-042 SHALL cover wrap and alignment: redirect to 'hFFFF_FFFF_FFFF_FFFE with ADDR_W = 64 -> req_addr 'h...FFFC, then 0x0 with no error.
REQ-043 SHALL cover reset mid-stream: rst low with 2 inflight and FIFO 3 full -> outputs at reset values immediately; after release the first req_addr = RESET_PC.
